// File: rtl/m_shiftreg_seq_if.sv
// Parallel/serial bus bundle for m_shiftreg_seq.
//
// Parallel side: in_valid/in_ready/in_data handshake plus the per-frame lsb_first select,
// and rx_data/rx_valid/done for the received word.
// Serial side: ser_out/ser_en transmit strobe pair and the ser_in receive bit.
// busy flags an active frame or its trailing gap.
//
// slave  : view used by the sequencer itself.
// master : view used by whatever drives the sequencer (producer/consumer side).
interface m_shiftreg_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             lsb_first;
  logic             ser_out;
  logic             ser_en;
  logic             ser_in;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             done;
  logic             busy;

  modport master (
    output in_valid,
    output in_data,
    output lsb_first,
    output ser_in,
    input  in_ready,
    input  ser_out,
    input  ser_en,
    input  rx_data,
    input  rx_valid,
    input  done,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  lsb_first,
    input  ser_in,
    output in_ready,
    output ser_out,
    output ser_en,
    output rx_data,
    output rx_valid,
    output done,
    output busy
  );
endinterface

// File: rtl/m_shiftreg_seq.sv
// Full-duplex shift-register sequencer.
//
// Accepts a WIDTH-bit word on a valid/ready handshake, then spends WIDTH cycles shifting it
// out on ser_out (ser_en high) while shifting ser_in into a receive register in the same bit
// order. The cycle after the last bit pulses done/rx_valid with the assembled word on rx_data,
// and GAP_CYCLES idle cycles follow before the next word can be accepted.
//
// Ports:
//   clk    : rising-edge clock.
//   reset  : synchronous, active-high reset; discards any partial frame.
//   bus    : m_shiftreg_seq_if slave view (handshake, serial pins, rx word, status).
module m_shiftreg_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  m_shiftreg_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Gap counter is loaded with GAP_CYCLES-1 and leaves GAP on reaching zero, so GAP lasts
  // exactly GAP_CYCLES cycles. Unused when GAP_CYCLES is zero.
  localparam logic [3:0] GapLoad = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             lsb_q, lsb_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             done_q, done_d;

  logic             in_ready;
  logic             ser_out;
  logic             ser_en;
  logic             busy;

  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] rx_next;

  // Transmit bit always sits at the end the frame order reads from; the register shifts
  // toward that end so the next bit is in place for the following cycle.
  always_comb begin
    if (lsb_q) begin
      tx_shifted = {1'b0, tx_q[WIDTH-1:1]};
      rx_next    = {bus.ser_in, rx_sh_q[WIDTH-1:1]};
    end else begin
      tx_shifted = {tx_q[WIDTH-2:0], 1'b0};
      rx_next    = {rx_sh_q[WIDTH-2:0], bus.ser_in};
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    lsb_d     = lsb_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    ser_out   = 1'b0;
    ser_en    = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          tx_d      = bus.in_data;
          lsb_d     = bus.lsb_first;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end

      StShift: begin
        ser_en    = 1'b1;
        busy      = 1'b1;
        ser_out   = lsb_q ? tx_q[0] : tx_q[WIDTH-1];
        tx_d      = tx_shifted;
        rx_sh_d   = rx_next;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == LastBit) begin
          // Last bit: publish the word including the bit sampled at this edge.
          rx_data_d = rx_next;
          done_d    = 1'b1;
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = GapLoad;
            state_d   = StGap;
          end else begin
            state_d   = StIdle;
          end
        end
      end

      StGap: begin
        busy = 1'b1;
        if (gap_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      lsb_q     <= 1'b0;
      bit_cnt_q <= '0;
      gap_cnt_q <= 4'd0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      lsb_q     <= lsb_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ser_out  = ser_out;
  assign bus.ser_en   = ser_en;
  assign bus.busy     = busy;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = done_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_m_shiftreg_seq.sv
// Bench for m_shiftreg_seq: two instances (GAP_CYCLES=2 and GAP_CYCLES=0) share one stimulus
// stream. A frame-level reference model (cycles since accept, bit lists) predicts every output
// of both instances each cycle; directed table rows and hand sequences add explicit checks.
module tb_m_shiftreg_seq;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         lsb_first;
  logic         ser_in;

  int checks   = 0;
  int failures = 0;

  m_shiftreg_seq_if #(.WIDTH(W)) bus_a ();
  m_shiftreg_seq_if #(.WIDTH(W)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.lsb_first = lsb_first;
  assign bus_a.ser_in    = ser_in;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.lsb_first = lsb_first;
  assign bus_b.ser_in    = ser_in;

  m_shiftreg_seq #(.WIDTH(W), .GAP_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  m_shiftreg_seq #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = dut_a, 1 = dut_b.
  int           gaps [2] = '{2, 0};
  bit           m_active [2];
  int           m_t [2];          // cycles since accept edge; 1..W shift, W+1..W+gap gap
  logic [W-1:0] m_word [2];
  bit           m_lsb [2];
  logic [W-1:0] m_bits [2];       // received bits in arrival order
  logic [W-1:0] m_rx [2];
  bit           m_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    bit acc;
    if (reset) begin
      m_active[i] = 0;
      m_t[i]      = 0;
      m_rx[i]     = '0;
      m_done[i]   = 0;
      return;
    end
    m_done[i] = 0;
    acc = !m_active[i] && in_valid;
    if (m_active[i]) begin
      if (m_t[i] <= W) begin
        m_bits[i][m_t[i]-1] = ser_in;
        if (m_t[i] == W) begin
          for (int k = 0; k < W; k++) begin
            if (m_lsb[i]) m_rx[i][k] = m_bits[i][k];
            else          m_rx[i][W-1-k] = m_bits[i][k];
          end
          m_done[i] = 1;
        end
      end
      m_t[i]++;
      if (m_t[i] > W + gaps[i]) m_active[i] = 0;
    end
    if (acc) begin
      m_active[i] = 1;
      m_t[i]      = 1;
      m_word[i]   = in_data;
      m_lsb[i]    = lsb_first;
    end
  endtask

  task automatic check_dut(input int i, input logic rdy, input logic en, input logic so,
                           input logic dn, input logic rv, input logic bsy,
                           input logic [W-1:0] rx);
    logic exp_en, exp_out;
    string tag;
    tag     = (i == 0) ? "g2" : "g0";
    exp_en  = m_active[i] && (m_t[i] <= W);
    exp_out = 1'b0;
    if (exp_en) exp_out = m_lsb[i] ? m_word[i][m_t[i]-1] : m_word[i][W-m_t[i]];
    chk({"model_in_ready_", tag}, rdy, !m_active[i]);
    chk({"model_ser_en_", tag}, en, exp_en);
    chk({"model_ser_out_", tag}, so, exp_out);
    chk({"model_done_", tag}, dn, m_done[i]);
    chk({"model_rx_valid_", tag}, rv, m_done[i]);
    chk({"model_busy_", tag}, bsy, m_active[i]);
    chk({"model_rx_data_", tag}, rx, m_rx[i]);
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_dut(0, bus_a.in_ready, bus_a.ser_en, bus_a.ser_out, bus_a.done, bus_a.rx_valid,
              bus_a.busy, bus_a.rx_data);
    check_dut(1, bus_b.in_ready, bus_b.ser_en, bus_b.ser_out, bus_b.done, bus_b.rx_valid,
              bus_b.busy, bus_b.rx_data);
  endtask

  // ser_stream / exp_serial are time-ordered: first bit on the wire at bit W-1.
  typedef struct {
    logic [W-1:0] data;
    logic         lsb;
    logic [W-1:0] ser_stream;
    logic [W-1:0] exp_serial;
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs [4];

  task automatic run_row(input vec_t v);
    logic [W-1:0] cap;
    in_valid  = 1'b1;
    in_data   = v.data;
    lsb_first = v.lsb;
    ser_in    = 1'b0;
    step();                                   // accept edge T0; now in T0+1
    cap = '0;
    for (int k = 0; k < W; k++) begin
      chk("row_ser_en", bus_a.ser_en, 1);
      chk("row_in_ready_shift", bus_a.in_ready, 0);
      cap[W-1-k] = bus_a.ser_out;
      in_valid   = 1'($urandom_range(0, 1));  // ignored while not ready
      in_data    = W'($urandom);
      lsb_first  = 1'($urandom_range(0, 1));
      ser_in     = v.ser_stream[W-1-k];
      step();
    end
    // T0+W+1
    in_valid = 1'b0;
    chk("row_serial_word", cap, v.exp_serial);
    chk("row_done_g2", bus_a.done, 1);
    chk("row_rx_valid_g2", bus_a.rx_valid, 1);
    chk("row_rx_data_g2", bus_a.rx_data, v.exp_rx);
    chk("row_ser_en_end", bus_a.ser_en, 0);
    chk("row_ser_out_end", bus_a.ser_out, 0);
    chk("row_in_ready_gap1", bus_a.in_ready, 0);
    chk("row_busy_gap1", bus_a.busy, 1);
    chk("row_done_g0", bus_b.done, 1);
    chk("row_rx_data_g0", bus_b.rx_data, v.exp_rx);
    chk("row_in_ready_g0", bus_b.in_ready, 1);
    step();                                   // T0+W+2
    chk("row_in_ready_gap2", bus_a.in_ready, 0);
    chk("row_done_once", bus_a.done, 0);
    chk("row_rx_hold", bus_a.rx_data, v.exp_rx);
    step();                                   // T0+W+3
    chk("row_in_ready_after_gap", bus_a.in_ready, 1);
    chk("row_busy_after_gap", bus_a.busy, 0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, lsb: 1'b0, ser_stream: 8'h3C, exp_serial: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{data: 8'h01, lsb: 1'b1, ser_stream: 8'h01, exp_serial: 8'h80, exp_rx: 8'h80};
    vecs[2] = '{data: 8'h6E, lsb: 1'b1, ser_stream: 8'hC5, exp_serial: 8'h76, exp_rx: 8'hA3};
    vecs[3] = '{data: 8'h5A, lsb: 1'b0, ser_stream: 8'hF1, exp_serial: 8'h5A, exp_rx: 8'hF1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    lsb_first = 1'b0;
    ser_in    = 1'b0;
    step();
    step();
    chk("reset_in_ready", bus_a.in_ready, 1);
    chk("reset_rx_data", bus_a.rx_data, 0);
    chk("reset_busy", bus_a.busy, 0);
    reset = 1'b0;
    step();

    foreach (vecs[r]) run_row(vecs[r]);

    // Back-to-back frames with no gap: accept at T0 and T0+W+1.
    in_valid  = 1'b1;
    in_data   = 8'hF0;
    lsb_first = 1'b0;
    step();
    in_data = 8'h0F;
    for (int k = 0; k < W; k++) begin
      chk("b2b_ser_en_first", bus_b.ser_en, 1);
      chk("b2b_ser_out_first", bus_b.ser_out, (k < 4) ? 1 : 0);
      ser_in = 1'($urandom_range(0, 1));
      step();
    end
    chk("b2b_done_first", bus_b.done, 1);
    chk("b2b_ser_en_low", bus_b.ser_en, 0);
    chk("b2b_in_ready", bus_b.in_ready, 1);
    step();                                   // second accept at this edge
    in_valid = 1'b0;
    chk("b2b_ser_en_second", bus_b.ser_en, 1);
    chk("b2b_ser_out_second", bus_b.ser_out, 0);
    for (int k = 0; k < W; k++) step();
    chk("b2b_done_second", bus_b.done, 1);
    repeat (4) step();

    // Reset in the middle of a frame.
    in_valid = 1'b1;
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (3) step();                        // now in T0+4
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_in_ready", bus_a.in_ready, 1);
    chk("midreset_ser_en", bus_a.ser_en, 0);
    chk("midreset_busy", bus_a.busy, 0);
    chk("midreset_done", bus_a.done, 0);
    chk("midreset_rx_valid", bus_a.rx_valid, 0);
    chk("midreset_rx_data", bus_a.rx_data, 0);
    step();
    chk("midreset_no_done", bus_a.done, 0);
    run_row(vecs[0]);

    // Reset coincident with a request in IDLE.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst_req_ser_en", bus_a.ser_en, 0);
    chk("rst_req_busy", bus_a.busy, 0);
    chk("rst_req_in_ready", bus_a.in_ready, 1);
    step();
    chk("rst_req_still_idle", bus_b.ser_en, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      lsb_first = 1'($urandom_range(0, 1));
      ser_in    = 1'($urandom_range(0, 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/m_shiftreg_seq.md
Name: m_shiftreg_seq

Overview:
Sequencer for a WIDTH-bit shift register used as a full-duplex serial port. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock with a frame-enable strobe. In the same cycles it shifts in a serial input and returns the received word with a one-cycle valid pulse. It sits between parallel producers/consumers and any serial link built from the team's shift-register stages.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
GAP_CYCLES, 1, idle cycles forced after each frame (ser_en=0, in_ready=0); legal range 0..15.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  parallel transmit word.
lsb_first  input  1  bit order for this frame; sampled only at accept.
ser_out  output  1  serial transmit bit.
ser_en  output  1  high on every cycle ser_out carries a valid frame bit.
ser_in  input  1  serial receive bit; sampled on edges ending ser_en cycles.
rx_data  output  WIDTH  last received word, held until the next frame completes.
rx_valid  output  1  one-cycle pulse when rx_data updates.
done  output  1  one-cycle pulse at frame end (same cycle as rx_valid).
busy  output  1  high in SHIFT and GAP.

Behaviour:
- Reset: sampled on the rising clk edge (synchronous, active-high). Overrides all other activity, including mid-frame. The next cycle is IDLE with in_ready=1, ser_out=0, ser_en=0, rx_data=0, rx_valid=0, done=0, busy=0. Bit counter=0, gap counter=0. A partial frame is discarded; no done or rx_valid pulse is produced.
- States: IDLE, SHIFT, GAP.
- IDLE: in_ready=1.
  - Accept occurs when in_valid&&in_ready at edge T0. At that edge, in_data is loaded into the TX shift register, lsb_first is latched, bit counter=0, and the state goes to SHIFT.
  - With no accept, the state stays IDLE.
- SHIFT: covers cycles T0+1..T0+WIDTH. In each: ser_en=1, busy=1, in_ready=0.
  - ser_out is bit k of the word: in_data[WIDTH-1-k] if MSB-first, in_data[k] if LSB-first, where k = 0..WIDTH-1.
  - At the edge ending each SHIFT cycle, ser_in is shifted into the RX register in the same order:
    - MSB-first: the first received bit lands in rx[WIDTH-1].
    - LSB-first: the first received bit lands in rx[0].
  - After the WIDTH-th bit, the state goes to GAP if GAP_CYCLES>0, else IDLE.
- Frame end, cycle T0+WIDTH+1: done=1 and rx_valid=1 for exactly one cycle, and rx_data holds the assembled word. ser_en=0 and ser_out=0.
- GAP: lasts exactly GAP_CYCLES cycles, starting at T0+WIDTH+1. busy=1, in_ready=0. The gap counter counts down, then the state goes to IDLE.
- Throughput: the minimum accept-to-accept spacing is WIDTH+GAP_CYCLES+1 cycles. With GAP_CYCLES=0, in_ready=1 at T0+WIDTH+1 and a back-to-back accept there is legal. In that case done/rx_valid for the old frame and the accept of the new frame coincide; both take effect.
- Outside SHIFT: ser_out=0 and ser_en=0. in_valid, in_data and lsb_first are ignored when in_ready=0.
- Stability: rx_data changes only at frame end and at reset. in_data may change freely after accept.
- Counter widths: bit counter is clog2(WIDTH+1) bits; gap counter is 4 bits. Neither counter wraps during legal operation.

Test Plan:
1. WIDTH=8, GAP_CYCLES=2, MSB-first: accept in_data=8'hA5 at edge T0 with ser_in fed 8'h3C MSB-first -> ser_out=1,0,1,0,0,1,0,1 with ser_en=1 in cycles T0+1..T0+8; at T0+9 done=rx_valid=1 and rx_data=8'h3C; in_ready=0 in T0+9..T0+10 and 1 at T0+11.
2. Same setup, lsb_first=1, in_data=8'h01, ser_in fed 8'h80 LSB-first -> ser_out=1,0,0,0,0,0,0,0; rx_data=8'h80.
3. GAP_CYCLES=0, in_valid held high with words 8'hF0 then 8'h0F -> second accept at T0+9; done pulses at T0+9 and T0+18; ser_en low only in cycle T0+9.
4. Reset asserted during cycle T0+4 of a frame -> next cycle all outputs at reset values, rx_data=0, no done/rx_valid pulse; the next accept proceeds normally.
5. in_valid toggling during SHIFT/GAP with in_data changing -> no extra accept, ser_out unaffected; in_ready=0 throughout.
6. Reset and in_valid=1 at the same edge in IDLE -> word not accepted; state IDLE and ser_en=0 the next cycle.
